// File: rtl/gpio_mod_counter.sv
// Modulo-N up/down counter with clear, load, one-shot stop, terminal pulse and wrap count.
// Latency: every output is registered, so it updates one cycle after its inputs are sampled. Backpressure: none; en gates each step.
module gpio_mod_counter #(
    parameter int WIDTH   = 10,
    parameter int MODULUS = 1000,
    parameter int WRAP_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              dir,
    input  logic              mode,
    input  logic              clr,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  data,
    output logic              tc,
    output logic              done,
    output logic [WRAP_W-1:0] wrap_cnt
);

    if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
        $error("gpio_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    localparam logic [WIDTH-1:0]  TERM_UP  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]    MOD_EXT  = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0]  DATA_ONE = WIDTH'(1);
    localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);

    logic [WIDTH-1:0]  data_q, data_d;
    logic              tc_q, tc_d;
    logic              done_q, done_d;
    logic [WRAP_W-1:0] wrap_q, wrap_d;

    logic [WIDTH-1:0]  term_val;
    logic              at_term;
    logic [WIDTH-1:0]  load_clamped;

    // The terminal follows the direction sampled on this very edge.
    assign term_val     = dir ? '0 : TERM_UP;
    assign at_term      = (data_q == term_val);
    assign load_clamped = ({1'b0, load_val} >= MOD_EXT) ? TERM_UP : load_val;

    always_comb begin
        data_d = data_q;
        tc_d   = 1'b0;
        done_d = done_q;
        wrap_d = wrap_q;
        if (clr) begin
            data_d = '0;
            done_d = 1'b0;
            wrap_d = '0;
        end else if (load) begin
            data_d = load_clamped;
            done_d = 1'b0;
        end else if (done_q) begin
            // Leaving one-shot only releases the stop; the next enabled edge does the step.
            if (!mode) begin
                done_d = 1'b0;
            end
        end else if (en) begin
            if (!at_term) begin
                data_d = dir ? (data_q - DATA_ONE) : (data_q + DATA_ONE);
            end else if (!mode) begin
                data_d = dir ? TERM_UP : '0;
                tc_d   = 1'b1;
                wrap_d = wrap_q + WRAP_ONE;
            end else begin
                done_d = 1'b1;
                tc_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
            tc_q   <= 1'b0;
            done_q <= 1'b0;
            wrap_q <= '0;
        end else begin
            data_q <= data_d;
            tc_q   <= tc_d;
            done_q <= done_d;
            wrap_q <= wrap_d;
        end
    end

    assign data     = data_q;
    assign tc       = tc_q;
    assign done     = done_q;
    assign wrap_cnt = wrap_q;

endmodule

// File: tb/tb_gpio_mod_counter.sv
// Bench for gpio_mod_counter: a 10-bit/1000 instance and a 3-bit/5 instance with a 4-bit wrap counter.
module tb_gpio_mod_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0, dir = 1'b0, mode = 1'b0, clr = 1'b0, load = 1'b0;
    logic [9:0]  load_val = '0;
    logic [9:0]  data;
    logic        tc, done;
    logic [15:0] wrap_cnt;

    logic        s_en = 1'b0, s_dir = 1'b0, s_mode = 1'b0, s_clr = 1'b0, s_load = 1'b0;
    logic [2:0]  s_load_val = '0;
    logic [2:0]  s_data;
    logic        s_tc, s_done;
    logic [3:0]  s_wrap_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gpio_mod_counter #(.WIDTH(10), .MODULUS(1000), .WRAP_W(16)) u_main (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode), .clr(clr),
        .load(load), .load_val(load_val), .data(data), .tc(tc), .done(done),
        .wrap_cnt(wrap_cnt)
    );

    gpio_mod_counter #(.WIDTH(3), .MODULUS(5), .WRAP_W(4)) u_small (
        .clk(clk), .reset(reset), .en(s_en), .dir(s_dir), .mode(s_mode), .clr(s_clr),
        .load(s_load), .load_val(s_load_val), .data(s_data), .tc(s_tc), .done(s_done),
        .wrap_cnt(s_wrap_cnt)
    );

    typedef struct {
        int data;
        bit tc;
        bit done;
        int wrap;
    } mstate_t;

    mstate_t mm, ms;

    // Reference behaviour written directly from the counting rules.
    function automatic mstate_t mstep(mstate_t s, int m, int ww, bit e, bit d, bit md,
                                      bit c, bit l, int lv);
        mstate_t n = s;
        n.tc = 1'b0;
        if (c) begin
            n.data = 0; n.wrap = 0; n.done = 1'b0;
        end else if (l) begin
            n.data = (lv >= m) ? m - 1 : lv;
            n.done = 1'b0;
        end else if (s.done) begin
            if (!md) n.done = 1'b0;
        end else if (e) begin
            if ((d && s.data != 0) || (!d && s.data != m - 1)) begin
                n.data = d ? s.data - 1 : s.data + 1;
            end else if (!md) begin
                n.data = d ? m - 1 : 0;
                n.tc   = 1'b1;
                n.wrap = (s.wrap + 1) % (1 << ww);
            end else begin
                n.done = 1'b1;
                n.tc   = 1'b1;
            end
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_main(input string tag);
        chk({tag, ".data"}, 32'(data), 32'(mm.data));
        chk({tag, ".tc"}, 32'(tc), 32'(mm.tc));
        chk({tag, ".done"}, 32'(done), 32'(mm.done));
        chk({tag, ".wrap"}, 32'(wrap_cnt), 32'(mm.wrap));
    endtask

    task automatic cmp_small(input string tag);
        chk({tag, ".s_data"}, 32'(s_data), 32'(ms.data));
        chk({tag, ".s_tc"}, 32'(s_tc), 32'(ms.tc));
        chk({tag, ".s_done"}, 32'(s_done), 32'(ms.done));
        chk({tag, ".s_wrap"}, 32'(s_wrap_cnt), 32'(ms.wrap));
    endtask

    task automatic tick(input bit cm, input bit cs);
        @(posedge clk);
        mm = mstep(mm, 1000, 16, en, dir, mode, clr, load, int'(load_val));
        ms = mstep(ms, 5, 4, s_en, s_dir, s_mode, s_clr, s_load, int'(s_load_val));
        #1;
        if (cm) cmp_main("model");
        if (cs) cmp_small("model");
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        {en, dir, mode, clr, load} = '0;
        {s_en, s_dir, s_mode, s_clr, s_load} = '0;
        load_val = '0;
        s_load_val = '0;
        mm = '{default: 0};
        ms = '{default: 0};
        #2;
        cmp_main("reset");
        cmp_small("reset");
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        bit en, dir, mode, clr, load;
        int lv;
        int e_data;
        bit e_tc, e_done;
        int e_wrap;
    } vec_t;

    function automatic vec_t mk(bit e, bit d, bit md, bit c, bit l, int lv,
                                int ed, bit et, bit edn, int ew);
        vec_t v;
        v.en = e; v.dir = d; v.mode = md; v.clr = c; v.load = l; v.lv = lv;
        v.e_data = ed; v.e_tc = et; v.e_done = edn; v.e_wrap = ew;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        int pulses;

        do_reset();

        //           en dir md clr ld  lv    data tc dn wrap
        tbl.push_back(mk(0, 0, 0, 0, 1, 1023, 999, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,    0,   1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,    1,   0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0,    0,   0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0,    999, 1, 0, 2));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0,    998, 0, 0, 2));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,    998, 0, 0, 2));
        tbl.push_back(mk(1, 0, 0, 1, 1, 1023, 0,   0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 995,  995, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0,    996, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0,    997, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0,    998, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0,    999, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0,    999, 1, 1, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0,    999, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0,    999, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,    999, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,    0,   1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 999,  999, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1, 5,    5,   0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0,    0,   0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            en = tbl[i].en; dir = tbl[i].dir; mode = tbl[i].mode;
            clr = tbl[i].clr; load = tbl[i].load; load_val = 10'(tbl[i].lv);
            tick(1, 0);
            chk($sformatf("tbl[%0d].data", i), 32'(data), 32'(tbl[i].e_data));
            chk($sformatf("tbl[%0d].tc", i), 32'(tc), 32'(tbl[i].e_tc));
            chk($sformatf("tbl[%0d].done", i), 32'(done), 32'(tbl[i].e_done));
            chk($sformatf("tbl[%0d].wrap", i), 32'(wrap_cnt), 32'(tbl[i].e_wrap));
        end

        // Two full free-running laps.
        do_reset();
        en = 1'b1;
        pulses = 0;
        repeat (2000) begin
            tick(1, 0);
            if (tc === 1'b1) pulses++;
        end
        chk("lap.pulses", 32'(pulses), 32'd2);
        chk("lap.wrap", 32'(wrap_cnt), 32'd2);
        chk("lap.data", 32'(data), 32'd0);

        dir = 1'b1;
        tick(1, 0);
        chk("down.data0", 32'(data), 32'd999);
        chk("down.tc0", 32'(tc), 32'd1);
        chk("down.wrap0", 32'(wrap_cnt), 32'd3);
        tick(1, 0);
        chk("down.data1", 32'(data), 32'd998);
        chk("down.tc1", 32'(tc), 32'd0);
        tick(1, 0);
        chk("down.data2", 32'(data), 32'd997);

        // Asynchronous reset in the middle of a count.
        do_reset();
        en = 1'b1;
        repeat (3500) tick(1, 0);
        chk("mid.data", 32'(data), 32'd500);
        chk("mid.wrap", 32'(wrap_cnt), 32'd3);
        chk("mid.done", 32'(done), 32'd0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        mm = '{default: 0};
        ms = '{default: 0};
        #1;
        chk("arst.data", 32'(data), 32'd0);
        chk("arst.tc", 32'(tc), 32'd0);
        chk("arst.done", 32'(done), 32'd0);
        chk("arst.wrap", 32'(wrap_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick(1, 0);
        chk("arst.first", 32'(data), 32'd1);

        // Small instance: en every other cycle, then a direction flip at 2.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            s_en = (i % 2 == 0);
            tick(0, 1);
            chk($sformatf("small.seq[%0d]", i), 32'(s_data), 32'(((i / 2) + 1) % 5));
            chk($sformatf("small.tc[%0d]", i), 32'(s_tc), 32'(i == 8));
        end
        s_en = 1'b1;
        tick(0, 1);
        tick(0, 1);
        chk("small.at2", 32'(s_data), 32'd2);
        s_dir = 1'b1;
        tick(0, 1);
        chk("small.flip", 32'(s_data), 32'd1);

        // Randomised traffic on both instances against the model.
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            en   = ($urandom_range(0, 3) != 0);
            dir  = ($urandom_range(0, 15) == 0) ? ~dir : dir;
            mode = ($urandom_range(0, 40) == 0) ? ~mode : mode;
            clr  = ($urandom_range(0, 127) == 0);
            load = ($urandom_range(0, 31) == 0);
            load_val = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(980, 1023))
                                                   : 10'($urandom_range(0, 1023));
            s_en   = ($urandom_range(0, 3) != 0);
            s_dir  = ($urandom_range(0, 7) == 0) ? ~s_dir : s_dir;
            s_mode = ($urandom_range(0, 20) == 0) ? ~s_mode : s_mode;
            s_clr  = ($urandom_range(0, 127) == 0);
            s_load = ($urandom_range(0, 15) == 0);
            s_load_val = 3'($urandom_range(0, 7));
            tick(1, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
